// File: rtl/cla_sub_pkg.sv
// Shared types and sizing helpers for the chunk-serial CLA subtractor.
package cla_sub_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic int calc_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-chunk configuration still needs a one-bit index register.
    function automatic int calc_idx_w(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/cla_group.sv
// Combinational CHUNK-bit carry-lookahead group: s = x + y + ci, with group carry-out.
// With CLA_SUB_SERIAL_OVF_EN defined, also exports the carry into the MSB.
module cla_group
    import cla_sub_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
`ifdef CLA_SUB_SERIAL_OVF_EN
    ,
    output logic             c_msb
`endif
);

    logic [CHUNK-1:0] g;
    logic [CHUNK-1:0] p;
    logic [CHUNK:0]   c;

    assign g = x & y;
    assign p = x ^ y;

    // Each carry is the flattened sum of generate terms gated by the propagate
    // products below them, so no carry depends on another computed carry.
    always_comb begin
        logic acc;
        logic pp;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < CHUNK; i++) begin
            acc = g[i];
            pp  = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc = acc | (pp & g[j]);
                pp  = pp & p[j];
            end
            acc      = acc | (pp & ci);
            c[i + 1] = acc;
        end
    end

    assign s  = p ^ c[CHUNK-1:0];
    assign co = c[CHUNK];

`ifdef CLA_SUB_SERIAL_OVF_EN
    assign c_msb = c[CHUNK-1];
`endif

endmodule

// File: rtl/cla_sub_serial.sv
// Chunk-serial unsigned subtractor d = a - b - bin, one CHUNK-bit lookahead slice per cycle.
// Optional signed-overflow output enabled by defining CLA_SUB_SERIAL_OVF_EN.
module cla_sub_serial
    import cla_sub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             out_valid,
    input  logic             out_ready
`ifdef CLA_SUB_SERIAL_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int IW     = calc_idx_w(NCHUNK);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry;
    logic [IW-1:0]    idx;
    logic [CHUNK-1:0] x;
    logic [CHUNK-1:0] y;
    logic [CHUNK-1:0] s;
    logic             co;
    logic             last;

`ifdef CLA_SUB_SERIAL_OVF_EN
    logic             c_msb;
`endif

    assign last = (idx == IW'(NCHUNK - 1));

    // Subtraction is a + ~b + ~bin, so the subtrahend slice is inverted on the way in.
    always_comb begin
        x = '0;
        y = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (idx == IW'(k)) begin
                x = a_reg[k*CHUNK +: CHUNK];
                y = ~b_reg[k*CHUNK +: CHUNK];
            end
        end
    end

    cla_group #(
        .CHUNK (CHUNK)
    ) u_group (
        .x     (x),
        .y     (y),
        .ci    (carry),
        .s     (s),
        .co    (co)
`ifdef CLA_SUB_SERIAL_OVF_EN
        ,
        .c_msb (c_msb)
`endif
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // The borrow out of the whole subtraction is the inverted final carry.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            carry     <= 1'b0;
            idx       <= '0;
            d         <= '0;
            bout      <= 1'b0;
            out_valid <= 1'b0;
`ifdef CLA_SUB_SERIAL_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= a;
                        b_reg <= b;
                        carry <= ~bin;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    for (int k = 0; k < NCHUNK; k++) begin
                        if (idx == IW'(k)) begin
                            d[k*CHUNK +: CHUNK] <= s;
                        end
                    end
                    carry <= co;
                    if (last) begin
                        idx       <= '0;
                        out_valid <= 1'b1;
                        bout      <= ~co;
`ifdef CLA_SUB_SERIAL_OVF_EN
                        ovf       <= c_msb ^ co;
`endif
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla_sub_serial.sv
// Directed self-checking bench for cla_sub_serial with hand-computed expected results.
// Define CLA_SUB_SERIAL_OVF_EN to also check the ovf output.
module tb_cla_sub_serial;

    logic        clk;
    logic        rst;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] d;
    logic        bout;
    logic        out_valid;
    logic        out_ready;
`ifdef CLA_SUB_SERIAL_OVF_EN
    logic        ovf;
`endif

    int n_vec  = 0;
    int n_fail = 0;
    int n_lat  = 0;

    cla_sub_serial #(
        .WIDTH (16),
        .CHUNK (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d         (d),
        .bout      (bout),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef CLA_SUB_SERIAL_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_vec++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Present operands for one accept edge; returns at the negedge after that edge.
    task automatic apply_stimulus(input logic [15:0] av, input logic [15:0] bv, input logic binv);
        @(negedge clk);
        a        = av;
        b        = bv;
        bin      = binv;
        in_valid = 1'b1;
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        a        = 16'hDEAD;
        b        = 16'hBEEF;
        bin      = ~binv;
    endtask

    // Counts edges until out_valid, bounded so a stuck DUT still reaches the summary.
    task automatic wait_valid(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic check_output(input string tag, input logic [15:0] exp_d, input logic exp_bout,
                                input logic exp_ovf);
        check({tag, "_d"}, 32'(d), 32'(exp_d));
        check({tag, "_bout"}, 32'(bout), 32'(exp_bout));
        check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
`ifdef CLA_SUB_SERIAL_OVF_EN
        check({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
`else
        if (exp_ovf === 1'bx) $display("[TB] unexpected unknown ovf expectation in %s", tag);
`endif
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_valid_cleared"}, 32'(out_valid), 32'd0);
        check({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic binv, input logic [15:0] exp_d, input logic exp_bout,
                          input logic exp_ovf);
        int n;
        apply_stimulus(av, bv, binv);
        check({tag, "_busy"}, 32'(in_ready), 32'd0);
        wait_valid(n);
        check({tag, "_latency"}, 32'(n), 32'd4);
        check_output(tag, exp_d, exp_bout, exp_ovf);
        handshake(tag);
    endtask

    initial begin
        rst       = 1'b1;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_d", 32'(d), 32'd0);
        check("reset_bout", 32'(bout), 32'd0);
`ifdef CLA_SUB_SERIAL_OVF_EN
        check("reset_ovf", 32'(ovf), 32'd0);
`endif
        rst = 1'b0;

        $display("[TB] directed vectors");
        run_op("v_1_minus_neg5_bin", 16'h0001, 16'hFFFB, 1'b1, 16'h0005, 1'b1, 1'b0);
        run_op("v_3_minus_fffb",     16'h0003, 16'hFFFB, 1'b0, 16'h0008, 1'b1, 1'b0);
        run_op("v_fffd_minus_2",     16'hFFFD, 16'h0002, 1'b0, 16'hFFFB, 1'b0, 1'b0);
        run_op("v_zero_ripple",      16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        run_op("v_ffff_minus_bin",   16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op("v_equal_operands",   16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0);
        run_op("v_equal_with_bin",   16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        run_op("v_ovf_neg",          16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
        run_op("v_no_ovf",           16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0);
        run_op("v_ovf_pos",          16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);

        $display("[TB] back-pressure hold");
        apply_stimulus(16'h0003, 16'hFFFB, 1'b0);
        wait_valid(n_lat);
        check("hold_latency", 32'(n_lat), 32'd4);
        a        = 16'hFFFD;
        b        = 16'h0002;
        bin      = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_d", 32'(d), 32'h0008);
            check("hold_bout", 32'(bout), 32'd1);
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("hold_release_valid", 32'(out_valid), 32'd0);
        check("hold_release_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("hold_next_accepted", 32'(in_ready), 32'd0);
        wait_valid(n_lat);
        check("hold_next_latency", 32'(n_lat), 32'd4);
        check_output("hold_next", 16'hFFFB, 1'b0, 1'b0);
        handshake("hold_next");

        $display("[TB] reset during run");
        apply_stimulus(16'h1234, 16'h0001, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_d", 32'(d), 32'd0);
        check("midrst_bout", 32'(bout), 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("midrst_no_valid", 32'(out_valid), 32'd0);
        end
        run_op("v_after_reset", 16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
